uart_rx_param: RTL and testbench
================================

# uart_rx_param

Parametrised UART receiver; successor to the fixed 8N1 `uart_rx`. It oversamples the asynchronous `rx` line, majority-votes each bit and frames words of configurable width, parity and stop bits. It presents each received word on a valid/ready handshake with per-word error flags. It sits between the board RX pin and any downstream consumer, such as a FIFO or command parser.

## Interface
- `CLK_FREQ`, 27000000: system clock frequency in Hz.
- `BAUD`, 9600: line rate in bit/s.
- `OVERSAMPLE`, 16: ticks per bit; even, ≥8.
- `DATA_BITS`, 8: data width, legal range 5–9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-high reset.
- `rx` in 1: asynchronous serial input; idle high.
- `data_out` out DATA_BITS: received word, LSB = first data bit.
- `data_valid` out 1: `data_out` and error flags hold a word.
- `data_ready` in 1: consumer accepts the word.
- `frame_err` out 1: stop bit sampled low; qualified by `data_valid`.
- `parity_err` out 1: parity mismatch; qualified by `data_valid`.
- `overrun` out 1: one-cycle pulse when a completed word is dropped.
- `rx_busy` out 1: high from start-bit detection until return to IDLE.

## Operation
- **Input synchronizer:** `rx` passes through 2 flops, both reset to 1. All logic uses the synchronized value.
- **Tick generator:** one-cycle `tick` every DIV = (CLK_FREQ + BAUD*OVERSAMPLE/2)/(BAUD*OVERSAMPLE) clocks (176 at the defaults). The counter restarts at 0 on leaving IDLE so the frame phase is aligned to the falling edge.
- **Bit sampling:** a tick counter (0..OVERSAMPLE-1) runs within each bit. Samples are taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the 2-of-3 majority, decided at tick OVERSAMPLE/2+1.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on a synchronized high→low transition.
  - START: if the majority is 1 (false start / glitch), go to IDLE with no output; otherwise at bit end go to DATA.
  - DATA: shift DATA_BITS bits LSB first. Then go to PARITY if PARITY≠0 (and the parity feature is compiled in), else STOP.
  - PARITY: compare the sampled bit with the computed parity. Odd: total ones including the parity bit is odd. Even: that total is even. Then go to STOP.
  - STOP: sample each stop bit. Any stop bit sampled low sets `frame_err`. At the decision tick of the last stop bit, commit the word and go straight to IDLE without waiting for the bit end, so a start bit arriving immediately after is caught.
- **Commit rules:**
  - If `data_valid`=0, or `data_valid`=1 with `data_ready`=1 in the same cycle: load `data_out`, `frame_err` and `parity_err`, and set `data_valid`=1.
  - If `data_valid`=1 and `data_ready`=0: drop the new word, leave held outputs unchanged, and pulse `overrun`.
- **Handshake:**
  - A transfer occurs on any cycle where `data_valid` and `data_ready` are both 1.
  - After a transfer, `data_valid` clears on the next edge unless a commit occurs in that same cycle.
  - `data_out` is stable while `data_valid`=1 and `data_ready`=0.

## Timing
- **Reset values:** `data_out`=0, `data_valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, `rx_busy`=0. FSM goes to IDLE; tick and bit counters go to 0.
- **Reset mid-frame:** the partial word is discarded and any held word is lost.
- **Synchronizer latency:** 2 clocks from pin to FSM.
- **Start detection:** `rx_busy` rises 1 clock after the synchronized falling edge.
- **Word latency:** `data_valid` rises 1 clock after the last stop-bit decision tick. That is about (OVERSAMPLE/2+2)/OVERSAMPLE of a bit into the stop bit, plus 3 clocks, measured from the stop-bit start.
- **Busy:** `rx_busy` falls in the same cycle `data_valid` rises, or 1 clock after a false start is rejected.
- **Throughput:** back-to-back frames with zero idle time are received without loss when `data_ready`=1.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state and parity checking exist; the `PARITY` parameter is honoured.
- `UART_RX_PARITY_EN` undefined: no PARITY state or parity logic; `PARITY` is ignored (the frame has no parity bit); `parity_err` is tied to 0.

## Test plan
- **8N1 basic:** defaults, 27 MHz clock, 104167 ns per bit; send 0xAA with `data_ready`=1 → `data_out`=8'hAA, one valid cycle, `frame_err`=0, `parity_err`=0.
- **Glitch rejection:** a 2 µs low pulse on idle `rx` → `rx_busy` pulses, `data_valid` never rises; a following 0x3C is still received correctly.
- **Framing error:** send 0x5A with the stop bit driven low → `data_out`=8'h5A, `frame_err`=1; the next good frame reports `frame_err`=0.
- **Even parity (macro on):** PARITY=2; send 0x07 with parity bit 1 → `parity_err`=0; resend with parity bit 0 → `parity_err`=1.
- **Overrun:** hold `data_ready`=0; send 0x55 then 0x0F → `data_out` stays 8'h55, `overrun` pulses exactly once; raising `data_ready` drops `data_valid` next clock.
- **Reset mid-frame + 9-bit/2-stop:** DATA_BITS=9, STOP_BITS=2; assert `reset` for 2 clocks during bit 4 → all outputs 0; the next frame 9'h1A5 is received with `data_out`=9'h1A5.

Source files
------------

// File: rtl/uart_rx_param_if.sv
// Receive-side handshake bundle for uart_rx_param: word, error flags and status toward the consumer.
interface uart_rx_param_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data_out;
   logic                 data_valid;
   logic                 data_ready;
   logic                 frame_err;
   logic                 parity_err;
   logic                 overrun;
   logic                 rx_busy;

   modport master (
      output data_out,
      output data_valid,
      output frame_err,
      output parity_err,
      output overrun,
      output rx_busy,
      input  data_ready
   );

   modport slave (
      input  data_out,
      input  data_valid,
      input  frame_err,
      input  parity_err,
      input  overrun,
      input  rx_busy,
      output data_ready
   );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with 2-of-3 bit voting and a valid/ready word output.
// Optional parity support is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_param #(
   parameter int CLK_FREQ   = 27000000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx,
   uart_rx_param_if.master  bus
);

   localparam int DIV    = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
   localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(DATA_BITS);

   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [TICK_W-1:0] T_S0     = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] T_S1     = TICK_W'(OVERSAMPLE / 2);
   localparam logic [TICK_W-1:0] T_DEC    = TICK_W'(OVERSAMPLE / 2 + 1);
   localparam logic [TICK_W-1:0] T_END    = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN  = (PARITY != 0);
   localparam bit PAR_ODD = (PARITY == 1);
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_PARITY} state_t;
`else
   // The frame carries no parity bit in this build; PARITY is accepted but has no effect.
   localparam bit PAR_EN  = 1'b0 && (PARITY != 0);
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t state_reg, state_next;

   logic [1:0]           sync_reg;
   logic                 rx_prev_reg;
   logic [DIV_W-1:0]     div_cnt_reg;
   logic [TICK_W-1:0]    tick_cnt_reg;
   logic [BIT_W-1:0]     bit_cnt_reg;
   logic                 stop_cnt_reg;
   logic [1:0]           samp_reg;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 fe_acc_reg;
   logic [DATA_BITS-1:0] data_out_reg;
   logic                 valid_reg;
   logic                 frame_err_reg;
   logic                 overrun_reg;

   logic rx_s;
   logic falling;
   logic tick;
   logic decide;
   logic bit_end;
   logic maj;
   logic last_stop;
   logic commit;

   assign rx_s      = sync_reg[1];
   assign falling   = rx_prev_reg & ~rx_s;
   assign tick      = (state_reg != S_IDLE) && (div_cnt_reg == DIV_LAST);
   assign decide    = tick && (tick_cnt_reg == T_DEC);
   assign bit_end   = tick && (tick_cnt_reg == T_END);
   assign maj       = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_s) | (samp_reg[1] & rx_s);
   assign last_stop = (STOP_BITS == 1) || stop_cnt_reg;
   assign commit    = (state_reg == S_STOP) && decide && last_stop;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_reg    <= 2'b11;
         rx_prev_reg <= 1'b1;
      end else begin
         sync_reg    <= {sync_reg[0], rx};
         rx_prev_reg <= rx_s;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_reg <= S_IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (falling) state_next = S_START;
         S_START: begin
            if (decide && maj)  state_next = S_IDLE;
            else if (bit_end)   state_next = S_DATA;
         end
         S_DATA: begin
            if (bit_end && (bit_cnt_reg == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
               state_next = PAR_EN ? S_PARITY : S_STOP;
`else
               state_next = S_STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: if (bit_end) state_next = S_STOP;
`endif
         // Leave on the decision tick, not the bit end, so an immediate next start edge is seen.
         S_STOP:  if (commit) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Baud tick divider and in-bit tick counter, both parked at zero while idle.
   always_ff @(posedge clk) begin
      if (reset || state_reg == S_IDLE) begin
         div_cnt_reg  <= '0;
         tick_cnt_reg <= '0;
      end else if (tick) begin
         div_cnt_reg  <= '0;
         tick_cnt_reg <= (tick_cnt_reg == T_END) ? '0 : tick_cnt_reg + 1'b1;
      end else begin
         div_cnt_reg  <= div_cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         samp_reg     <= 2'b11;
         bit_cnt_reg  <= '0;
         stop_cnt_reg <= 1'b0;
         shift_reg    <= '0;
         fe_acc_reg   <= 1'b0;
      end else begin
         if (tick && tick_cnt_reg == T_S0) samp_reg[0] <= rx_s;
         if (tick && tick_cnt_reg == T_S1) samp_reg[1] <= rx_s;

         if (state_reg == S_START)
            bit_cnt_reg <= '0;
         else if (state_reg == S_DATA && bit_end)
            bit_cnt_reg <= bit_cnt_reg + 1'b1;

         if (state_reg == S_DATA && decide)
            shift_reg <= {maj, shift_reg[DATA_BITS-1:1]};

         if (state_reg != S_STOP)
            stop_cnt_reg <= 1'b0;
         else if (bit_end)
            stop_cnt_reg <= 1'b1;

         if (state_reg == S_START)
            fe_acc_reg <= 1'b0;
         else if (state_reg == S_STOP && decide && !maj)
            fe_acc_reg <= 1'b1;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic pe_acc_reg;
   logic parity_err_reg;

   // Error when the ones count over data plus parity bit has the wrong polarity.
   always_ff @(posedge clk) begin
      if (reset || state_reg == S_START)
         pe_acc_reg <= 1'b0;
      else if (state_reg == S_PARITY && decide)
         pe_acc_reg <= (^shift_reg) ^ maj ^ PAR_ODD;
   end

   always_ff @(posedge clk) begin
      if (reset)
         parity_err_reg <= 1'b0;
      else if (commit && (!valid_reg || bus.data_ready))
         parity_err_reg <= pe_acc_reg;
   end

   assign bus.parity_err = parity_err_reg;
`else
   assign bus.parity_err = PAR_EN;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         data_out_reg  <= '0;
         valid_reg     <= 1'b0;
         frame_err_reg <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         overrun_reg <= 1'b0;
         if (commit) begin
            if (!valid_reg || bus.data_ready) begin
               data_out_reg  <= shift_reg;
               frame_err_reg <= fe_acc_reg | ~maj;
               valid_reg     <= 1'b1;
            end else begin
               overrun_reg <= 1'b1;
            end
         end else if (valid_reg && bus.data_ready) begin
            valid_reg <= 1'b0;
         end
      end
   end

   assign bus.data_out   = data_out_reg;
   assign bus.data_valid = valid_reg;
   assign bus.frame_err  = frame_err_reg;
   assign bus.overrun    = overrun_reg;
   assign bus.rx_busy    = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 receiver and a 9-bit even-parity two-stop receiver side by side.
`timescale 1ns/1ps
module tb_uart_rx_param;

   localparam int CLK_HZ   = 3_200_000;
   localparam int BAUD_R   = 100_000;
   localparam int OS       = 16;
   // (3.2 MHz + 0.8 MHz) / 1.6 MHz = 2 clocks per tick, 16 ticks per bit
   localparam int BIT_CLKS = 32;
`ifdef UART_RX_PARITY_EN
   localparam bit B_PAR = 1'b1;
`else
   localparam bit B_PAR = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rx_a = 1'b1;
   logic rx_b = 1'b1;

   always #5 clk = ~clk;

   uart_rx_param_if #(.DATA_BITS(8)) ifa ();
   uart_rx_param_if #(.DATA_BITS(9)) ifb ();

   uart_rx_param #(.CLK_FREQ(CLK_HZ), .BAUD(BAUD_R), .OVERSAMPLE(OS),
                   .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
      .clk(clk), .reset(reset), .rx(rx_a), .bus(ifa));

   uart_rx_param #(.CLK_FREQ(CLK_HZ), .BAUD(BAUD_R), .OVERSAMPLE(OS),
                   .DATA_BITS(9), .PARITY(2), .STOP_BITS(2)) dut_b (
      .clk(clk), .reset(reset), .rx(rx_b), .bus(ifb));

   typedef struct {
      logic [8:0] data;
      logic       fe;
      logic       pe;
   } word_t;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic [7:0] exp_data;
      logic       exp_fe;
   } vec_t;

   int checks = 0;
   int failures = 0;
   word_t exp_a[$];
   word_t exp_b[$];
   int vcyc_a = 0, ovr_a = 0, ovr_b = 0;
   logic va_prev = 1'b0, vb_prev = 1'b0, busy_a_prev = 1'b0, busy_b_prev = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_word(input bit sel, input logic [8:0] d, input logic fe, input logic pe);
      word_t w;
      if ((sel ? exp_b.size() : exp_a.size()) == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_word_%0d: got %0h expected no word", sel, d);
         return;
      end
      w = sel ? exp_b.pop_front() : exp_a.pop_front();
      $display("word dut%0d data=%0h fe=%0b pe=%0b (expect %0h %0b %0b)", sel, d, fe, pe, w.data, w.fe, w.pe);
      chk($sformatf("data_%0d", sel), 32'(d), 32'(w.data));
      chk($sformatf("frame_err_%0d", sel), 32'(fe), 32'(w.fe));
      chk($sformatf("parity_err_%0d", sel), 32'(pe), 32'(w.pe));
   endtask

   // Monitor: consumes transfers against the expected queues and watches valid/busy ordering.
   always begin
      @(negedge clk);
      #1;
      if (!reset) begin
         if (ifa.data_valid) vcyc_a++;
         if (ifa.overrun) ovr_a++;
         if (ifb.overrun) ovr_b++;
         if (ifa.data_valid && !va_prev) begin
            chk("busy_low_at_valid_a", 32'(ifa.rx_busy), 0);
            chk("busy_before_valid_a", 32'(busy_a_prev), 1);
         end
         if (ifb.data_valid && !vb_prev)
            chk("busy_low_at_valid_b", 32'(ifb.rx_busy), 0);
         if (ifa.data_valid && ifa.data_ready)
            check_word(1'b0, {1'b0, ifa.data_out}, ifa.frame_err, ifa.parity_err);
         if (ifb.data_valid && ifb.data_ready)
            check_word(1'b1, ifb.data_out, ifb.frame_err, ifb.parity_err);
      end
      va_prev = ifa.data_valid;
      vb_prev = ifb.data_valid;
      busy_a_prev = ifa.rx_busy;
      busy_b_prev = ifb.rx_busy;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input bit sel, input logic v);
      if (sel) rx_b = v;
      else     rx_a = v;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_frame(input bit sel, input logic [8:0] d, input int nbits, input bit has_par,
                             input logic par, input int nstop, input logic [1:0] stops);
      drive(sel, 1'b0);
      for (int i = 0; i < nbits; i++) drive(sel, d[i]);
      if (has_par) drive(sel, par);
      for (int s = 0; s < nstop; s++) drive(sel, stops[s]);
      if (sel) rx_b = 1'b1;
      else     rx_a = 1'b1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_data_a"}, 32'(ifa.data_out), 0);
      chk({tag, "_valid_a"}, 32'(ifa.data_valid), 0);
      chk({tag, "_fe_a"}, 32'(ifa.frame_err), 0);
      chk({tag, "_pe_a"}, 32'(ifa.parity_err), 0);
      chk({tag, "_ovr_a"}, 32'(ifa.overrun), 0);
      chk({tag, "_busy_a"}, 32'(ifa.rx_busy), 0);
      chk({tag, "_data_b"}, 32'(ifb.data_out), 0);
      chk({tag, "_valid_b"}, 32'(ifb.data_valid), 0);
      chk({tag, "_fe_b"}, 32'(ifb.frame_err), 0);
      chk({tag, "_pe_b"}, 32'(ifb.parity_err), 0);
      chk({tag, "_ovr_b"}, 32'(ifb.overrun), 0);
      chk({tag, "_busy_b"}, 32'(ifb.rx_busy), 0);
   endtask

   // Independent reference: a word's errors follow directly from the bits put on the line.
   function automatic word_t model_b(input logic [8:0] d, input logic par, input logic [1:0] stops);
      word_t w;
      w.data = d;
      w.fe   = (stops != 2'b11);
      w.pe   = B_PAR ? (($countones(d) + int'(par)) % 2 != 0) : 1'b0;
      return w;
   endfunction

   initial begin
      #900_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[6];
      int v0, o0;
      logic seen_busy, seen_valid;
      logic [8:0] d;
      logic par, stop_low;
      logic [1:0] stops;
      int gap;

      tbl[0] = '{8'hAA, 1'b1, 8'hAA, 1'b0};
      tbl[1] = '{8'h00, 1'b1, 8'h00, 1'b0};
      tbl[2] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
      tbl[3] = '{8'h5A, 1'b0, 8'h5A, 1'b1};
      tbl[4] = '{8'hC3, 1'b1, 8'hC3, 1'b0};
      tbl[5] = '{8'h01, 1'b1, 8'h01, 1'b0};

      ifa.data_ready = 1'b1;
      ifb.data_ready = 1'b1;
      reset = 1'b1;
      idle(3);
      reset = 1'b0;
      #1;
      check_zero("reset");
      idle(2 * BIT_CLKS);

      // Table: 8N1 words including a framing error followed by good frames.
      v0 = vcyc_a;
      for (int i = 0; i < 6; i++) begin
         exp_a.push_back('{{1'b0, tbl[i].exp_data}, tbl[i].exp_fe, 1'b0});
         send_frame(1'b0, {1'b0, tbl[i].data}, 8, 1'b0, 1'b0, 1, {1'b1, tbl[i].stop});
         idle(BIT_CLKS);
         chk("tbl_consumed", 32'(exp_a.size()), 0);
      end
      chk("tbl_valid_cycles", 32'(vcyc_a - v0), 6);

      // Glitch shorter than the sample window must be rejected.
      rx_a = 1'b0;
      idle(3);
      rx_a = 1'b1;
      seen_busy = 1'b0;
      seen_valid = 1'b0;
      repeat (2 * BIT_CLKS) begin
         @(negedge clk);
         #1;
         if (ifa.rx_busy) seen_busy = 1'b1;
         if (ifa.data_valid) seen_valid = 1'b1;
      end
      chk("glitch_busy_seen", 32'(seen_busy), 1);
      chk("glitch_no_valid", 32'(seen_valid), 0);
      chk("glitch_busy_idle", 32'(ifa.rx_busy), 0);
      exp_a.push_back('{9'h03C, 1'b0, 1'b0});
      send_frame(1'b0, 9'h03C, 8, 1'b0, 1'b0, 1, 2'b11);
      idle(BIT_CLKS);
      chk("glitch_next_consumed", 32'(exp_a.size()), 0);

      // Even parity on the 9-bit receiver.
      exp_b.push_back('{9'h007, 1'b0, 1'b0});
      send_frame(1'b1, 9'h007, 9, B_PAR, 1'b1, 2, 2'b11);
      exp_b.push_back('{9'h007, 1'b0, B_PAR});
      send_frame(1'b1, 9'h007, 9, B_PAR, 1'b0, 2, 2'b11);
      idle(BIT_CLKS);
      chk("parity_consumed", 32'(exp_b.size()), 0);

      // Overrun: second word dropped while the first is held.
      ifa.data_ready = 1'b0;
      o0 = ovr_a;
      send_frame(1'b0, 9'h055, 8, 1'b0, 1'b0, 1, 2'b11);
      send_frame(1'b0, 9'h00F, 8, 1'b0, 1'b0, 1, 2'b11);
      idle(BIT_CLKS);
      chk("ovr_valid_held", 32'(ifa.data_valid), 1);
      chk("ovr_data_held", 32'(ifa.data_out), 32'h55);
      chk("ovr_pulses", 32'(ovr_a - o0), 1);
      exp_a.push_back('{9'h055, 1'b0, 1'b0});
      ifa.data_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("ovr_valid_drop", 32'(ifa.data_valid), 0);
      chk("ovr_consumed", 32'(exp_a.size()), 0);

      // Reset during bit 4 of a 9-bit frame while a word is held.
      ifb.data_ready = 1'b0;
      send_frame(1'b1, 9'h0F0, 9, B_PAR, 1'b0, 2, 2'b11);
      idle(4);
      chk("hold_b_valid", 32'(ifb.data_valid), 1);
      drive(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0);
      rx_b = 1'b1;
      idle(BIT_CLKS / 2);
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      #1;
      check_zero("midreset");
      idle(2 * BIT_CLKS);
      ifb.data_ready = 1'b1;
      exp_b.push_back('{9'h1A5, 1'b0, 1'b0});
      send_frame(1'b1, 9'h1A5, 9, B_PAR, 1'b1, 2, 2'b11);
      idle(BIT_CLKS);
      chk("midreset_next_consumed", 32'(exp_b.size()), 0);

      // Randomised frames, mostly back to back, on both receivers.
      o0 = ovr_a;
      for (int i = 0; i < 16; i++) begin
         d = 9'($urandom_range(0, 255));
         gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(4, 40));
         stop_low = (gap > 0) && ($urandom_range(0, 3) == 0);
         exp_a.push_back('{d, stop_low, 1'b0});
         send_frame(1'b0, d, 8, 1'b0, 1'b0, 1, {1'b1, ~stop_low});
         idle(gap);
      end
      idle(BIT_CLKS);
      chk("rand_a_consumed", 32'(exp_a.size()), 0);
      chk("rand_a_no_overrun", 32'(ovr_a - o0), 0);

      o0 = ovr_b;
      for (int i = 0; i < 10; i++) begin
         d = 9'($urandom_range(0, 511));
         par = 1'($urandom_range(0, 1));
         gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(4, 40));
         stops = (gap > 0) ? 2'($urandom_range(0, 3)) : 2'b11;
         exp_b.push_back(model_b(d, par, stops));
         send_frame(1'b1, d, 9, B_PAR, par, 2, stops);
         idle(gap);
      end
      idle(BIT_CLKS);
      chk("rand_b_consumed", 32'(exp_b.size()), 0);
      chk("rand_b_no_overrun", 32'(ovr_b - o0), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
